inst_fetch_stack: RTL and testbench

Parametrised next-generation program counter and fetch-address unit for the basic processor. Extends the flat 10-bit PC with:
- configurable PC width
- absolute and PC-relative branches
- a hardware return-address stack for call/return
- a stall input, and a start-address load

Drives the instruction memory address each cycle.

---
 rtl/inst_fetch_stack_pkg.sv | 7 +
 rtl/inst_fetch_stack_if.sv | 39 +++
 rtl/inst_fetch_stack_ret_addr_stack.sv | 35 +++
 rtl/inst_fetch_stack.sv | 63 ++++++
 tb/tb_inst_fetch_stack.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/inst_fetch_stack_pkg.sv
// inst_fetch_pkg: shared defaults, next-PC select encoding and perf counter width
package inst_fetch_pkg;
  localparam int PC_W_DEF = 10;
  localparam int DEPTH_DEF = 4;
  localparam int PERF_W = 16;
  typedef enum logic [2:0] {SEL_START, SEL_HOLD, SEL_RET, SEL_CALL, SEL_BRANCH, SEL_INC} pc_sel_e;
endpackage

// File: rtl/inst_fetch_stack_if.sv
// inst_fetch_stack_if: fetch control bus; master drives requests, slave returns PC/stack status.
// Ports: Start/StartAddr, Stall, BranchEn/BranchOnFlag/branch_flag/BranchRel/Target, CallEn, RetEn
// in; ProgCtr, StackDepth, StackErr out; BranchCount out when INSTFETCH_PERF_EN is defined.
interface inst_fetch_stack_if #(
  parameter int PC_W = 10,
  parameter int DEPTH = 4,
  parameter int SD_W = $clog2(DEPTH + 1)
) ();
  logic Start;
  logic [PC_W-1:0] StartAddr;
  logic Stall;
  logic BranchEn;
  logic BranchOnFlag;
  logic branch_flag;
  logic BranchRel;
  logic [PC_W-1:0] Target;
  logic CallEn;
  logic RetEn;
  logic [PC_W-1:0] ProgCtr;
  logic [SD_W-1:0] StackDepth;
  logic StackErr;
`ifdef INSTFETCH_PERF_EN
  logic [15:0] BranchCount;
`endif
  modport master (
    output Start, StartAddr, Stall, BranchEn, BranchOnFlag, branch_flag, BranchRel, Target, CallEn, RetEn,
    input ProgCtr, StackDepth, StackErr
`ifdef INSTFETCH_PERF_EN
    , input BranchCount
`endif
  );
  modport slave (
    input Start, StartAddr, Stall, BranchEn, BranchOnFlag, branch_flag, BranchRel, Target, CallEn, RetEn,
    output ProgCtr, StackDepth, StackErr
`ifdef INSTFETCH_PERF_EN
    , output BranchCount
`endif
  );
endinterface

// File: rtl/inst_fetch_stack_ret_addr_stack.sv
// ret_addr_stack: DEPTH-entry LIFO of return addresses.
// Ports: clk, rst_n (async active-low), clr (sync), push/pop/din in; top, depth, full, empty out.
// Push while full and pop while empty are ignored; push wins if both are requested.
module ret_addr_stack #(
  parameter int W = 10,
  parameter int DEPTH = 4,
  parameter int SD_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [SD_W-1:0] depth,
  output logic full,
  output logic empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [SD_W-1:0] depth_q, depth_d, below;
  assign full = depth_q == SD_W'(DEPTH);
  assign empty = depth_q == '0;
  assign below = depth_q - SD_W'(1);
  assign top = mem[below[AW-1:0]];
  assign depth = depth_q;
  always_comb
    depth_d = clr ? '0 : (push && !full) ? depth_q + SD_W'(1) : (pop && !empty) ? below : depth_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth_q <= '0;
    else depth_q <= depth_d;
  always_ff @(posedge clk)
    if (push && !full && !clr) mem[depth_q[AW-1:0]] <= din;
endmodule

// File: rtl/inst_fetch_stack.sv
// inst_fetch_stack: program counter with absolute/relative branches, call/return stack, stall and start load.
// Ports: Clk, Reset (async active-low), bus (inst_fetch_stack_if.slave).
// Optional INSTFETCH_PERF_EN adds a saturating BranchCount of taken flow changes.
module inst_fetch_stack
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SD_W = $clog2(DEPTH + 1)
) (
  input logic Clk,
  input logic Reset,
  inst_fetch_stack_if.slave bus
);
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt, top;
  logic err_q, err_d, full, empty, push, pop, taken;
  pc_sel_e sel;
  assign pc_inc = pc_q + PC_W'(1);
  // same-width add is the sign-extended offset modulo 2^PC_W
  assign tgt = bus.BranchRel ? pc_q + bus.Target : bus.Target;
  assign taken = bus.BranchEn && (!bus.BranchOnFlag || bus.branch_flag);
  always_comb
    sel = bus.Start ? SEL_START : bus.Stall ? SEL_HOLD : bus.RetEn ? SEL_RET :
          bus.CallEn ? SEL_CALL : taken ? SEL_BRANCH : SEL_INC;
  assign push = sel == SEL_CALL && !full;
  assign pop = sel == SEL_RET && !empty;
  // failed call/return fall through to a plain increment
  always_comb
    pc_d = sel == SEL_START ? bus.StartAddr : sel == SEL_HOLD ? pc_q : pop ? top :
           (push || sel == SEL_BRANCH) ? tgt : pc_inc;
  assign err_d = err_q || (sel == SEL_RET && empty) || (sel == SEL_CALL && full);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      pc_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      err_q <= err_d;
    end
  ret_addr_stack #(.W(PC_W), .DEPTH(DEPTH), .SD_W(SD_W)) u_ras (
    .clk(Clk),
    .rst_n(Reset),
    .clr(sel == SEL_START),
    .push(push),
    .pop(pop),
    .din(pc_inc),
    .top(top),
    .depth(bus.StackDepth),
    .full(full),
    .empty(empty)
  );
  assign bus.ProgCtr = pc_q;
  assign bus.StackErr = err_q;
`ifdef INSTFETCH_PERF_EN
  logic [PERF_W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = sel == SEL_START ? '0 : ((pop || push || sel == SEL_BRANCH) && !(&cnt_q)) ? cnt_q + PERF_W'(1) : cnt_q;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.BranchCount = cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch_stack.sv
// tb_inst_fetch_stack: directed plus random stimulus, queue-based scoreboard against a behavioural model.
module tb_inst_fetch_stack;
  localparam int PC_W = 10;
  localparam int DEPTH = 4;
  localparam int M = 1 << PC_W;
  typedef struct {
    int pc;
    int depth;
    bit err;
    int cnt;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int m_pc = 0;
  int m_cnt = 0;
  bit m_err = 0;
  int m_stk[$];
  logic Clk = 0;
  logic Reset = 1;
  inst_fetch_stack_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();
  inst_fetch_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_all(exp_t e);
    check("ProgCtr", int'(bus.ProgCtr), e.pc);
    check("StackDepth", int'(bus.StackDepth), e.depth);
    check("StackErr", int'(bus.StackErr), int'(e.err));
`ifdef INSTFETCH_PERF_EN
    check("BranchCount", int'(bus.BranchCount), e.cnt);
`endif
  endtask

  always @(posedge Clk) begin
    #1;
    if (sb.size() != 0) check_all(sb.pop_front());
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 0;
    m_pc = 0;
    m_stk.delete();
    m_err = 0;
    m_cnt = 0;
    #1;
    check_all('{0, 0, 1'b0, 0});
  endtask

  task automatic step(bit st, int sa, bit stl, bit ben, bit bof, bit flg, bit rel, int tg, bit call, bit ret);
    int off, tv;
    bit flow;
    @(negedge Clk);
    Reset = 1;
    bus.Start = st;
    bus.StartAddr = PC_W'(sa);
    bus.Stall = stl;
    bus.BranchEn = ben;
    bus.BranchOnFlag = bof;
    bus.branch_flag = flg;
    bus.BranchRel = rel;
    bus.Target = PC_W'(tg);
    bus.CallEn = call;
    bus.RetEn = ret;
    off = tg >= M / 2 ? tg - M : tg;
    tv = rel ? ((m_pc + off) % M + M) % M : tg;
    flow = 0;
    if (st) begin
      m_pc = sa;
      m_stk.delete();
      m_cnt = 0;
    end else if (!stl) begin
      if (ret) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back();
          flow = 1;
        end else begin
          m_pc = (m_pc + 1) % M;
          m_err = 1;
        end
      end else if (call) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % M);
          m_pc = tv;
          flow = 1;
        end else begin
          m_pc = (m_pc + 1) % M;
          m_err = 1;
        end
      end else if (ben && (!bof || flg)) begin
        m_pc = tv;
        flow = 1;
      end else m_pc = (m_pc + 1) % M;
      if (flow && m_cnt < 65535) m_cnt++;
    end
    sb.push_back('{m_pc, m_stk.size(), m_err, m_cnt});
  endtask

  task automatic inc(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    {bus.Start, bus.Stall, bus.BranchEn, bus.BranchOnFlag, bus.branch_flag, bus.BranchRel, bus.CallEn, bus.RetEn} = '0;
    bus.StartAddr = '0;
    bus.Target = '0;
    #2;
    Reset = 0;
    #1;
    check_all('{0, 0, 1'b0, 0});
    inc(7);
    do_reset();
    inc(3);
    repeat (3) step(1, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    inc(2);
    step(0, 0, 0, 1, 1, 1, 0, 1000, 0, 0);
    repeat (2) step(0, 0, 0, 1, 1, 0, 0, 300, 0, 0);
    inc(18);
    step(0, 0, 0, 1, 0, 0, 1, 'h3F0, 0, 0);
    inc(20);
    step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 50, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 50, 1, 1);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 200, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0, 0, 77, 1, 0);
    inc(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 59) == 0, int'($urandom_range(0, M - 1)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, M - 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end
    repeat (2) @(posedge Clk);
    #2;
    check("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
